chan_scan_mux: RTL and testbench
================================

# chan_scan_mux

Parametrised, registered N-channel, W-bit multiplexer with two selection modes:
- **Manual:** the selection comes from an input.
- **Auto-scan:** an internal divider steps the selection round-robin through all channels.

It generalises the fixed 4:1 combinational selector. It sits between the datapath and the board display/debug path, where scanned channel output drives time-multiplexed seven-segment digits and LED banks.

## Interface
Parameters:
- `WIDTH`, 5, bits per channel.
- `CHANNELS`, 4, number of input channels (≥2).
- `SEL_W`, `$clog2(CHANNELS)`, selection width (derived, not overridden).
- `DIV_W`, 16, width of scan-period counter.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = manual, 1 = auto-scan.
- `sel_in`  in  SEL_W  manual channel select.
- `hold`  in  1  auto mode: freeze divider and selection.
- `period`  in  DIV_W  auto mode: cycles per channel minus one.
- `din`  in  CHANNELS*WIDTH  packed inputs; channel k = `din[k*WIDTH +: WIDTH]`.
- `dout`  out  WIDTH  registered selected data.
- `sel_out`  out  SEL_W  registered current selection.
- `ch_onehot`  out  CHANNELS  one-hot of `sel_out` (digit enables).
- `step`  out  1  one-cycle pulse: selection advanced in auto mode.
- `sel_err`  out  1  one-cycle pulse: manual `sel_in` ≥ CHANNELS was rejected.

## Operation
- Reset (`rst`=1 at an edge) sets the following, overriding all other inputs:
  - `sel_out`=0, `ch_onehot`=1, `dout`=0.
  - `step`=0, `sel_err`=0, divider count=0.
- `sel_next` is computed combinationally each cycle:
  - **Manual (`mode`=0):**
    - If `sel_in` < CHANNELS, `sel_next`=`sel_in`.
    - Otherwise `sel_next`=`sel_out` and `sel_err`←1.
    - The divider count is cleared every manual cycle.
    - `hold` is ignored.
  - **Auto (`mode`=1, `hold`=0):**
    - If count ≥ `period`, count←0, `sel_next`=`sel_out`+1, wrapping CHANNELS-1→0, and `step`←1.
    - Otherwise count←count+1 and `sel_next`=`sel_out`.
  - **Auto with `hold`=1:** count and `sel_out` are frozen, `step`←0.
- At every non-reset edge:
  - `sel_out`←`sel_next`.
  - `ch_onehot`←1<<`sel_next`.
  - `dout`←channel `sel_next` of the current `din`.
- `dout` is refreshed every cycle, so data changes on the held channel propagate with no selection change.
- The `≥` comparison is deliberate. If `period` is lowered below the current count, the channel advances on the next edge; the count never runs away.
- `period`=0 advances the selection every cycle.
- Switching manual→auto resumes scanning from the current `sel_out` with count 0. Switching auto→manual takes `sel_in` at the next edge.
- Non-power-of-two CHANNELS must wrap at CHANNELS-1, never at 2^SEL_W-1.

## Timing
- Latency is 1 cycle from `din`/`sel_in` to `dout`/`sel_out`. There is no combinational input→output path.
- Auto dwell per channel is `period`+1 cycles. A full scan is CHANNELS×(`period`+1) cycles.
- `step` and `sel_err` are high for exactly one cycle, aligned with the `sel_out` update they report.
- `rst` asserted mid-scan takes effect at that edge. The first auto step after reset release occurs `period`+1 cycles later.

## Structure
- A shared package `board_pkg` holds:
  - `MODE_MANUAL`=1'b0 and `MODE_AUTO`=1'b1.
  - The default `DIV_W`.
- Sub-module `scan_divider` (parameter `DIV_W`) contains:
  - Inputs `clk`, `rst`, `en` (= `mode` & ~`hold`), `clr` (= ~`mode`), `period`.
  - Output `tick`.
  - The count register and ≥ compare.
- The top level holds the selection register, wrap logic, one-hot decode and the output register.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with arbitrary inputs → `dout`=0, `sel_out`=0, `ch_onehot`=4'b0001, `step`=0.
- **Manual:** `din`={5'd3,5'd2,5'd1,5'd0} (channel k = k), `sel_in`=2 → the next cycle gives `dout`=2, `ch_onehot`=4'b0100. Changing `din` channel 2 to 17 → `dout`=17 one cycle later.
- **Auto scan:** `period`=2 →
  - `sel_out` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - `step` pulses every 3rd cycle.
  - `dout` tracks the channel value.
- **Hold and period change:**
  - In auto, assert `hold` for 5 cycles → `sel_out` and `step` frozen. Release → the dwell resumes from the held count.
  - With count=5 and `period` dropped 10→1 → advance on the next edge.
- **Out-of-range and odd count:** CHANNELS=5, SEL_W=3.
  - Manual `sel_in`=6 → `sel_out` unchanged, one `sel_err` pulse.
  - Auto `period`=0 → `sel_out` 0,1,2,3,4,0.
- **Mid-operation reset and mode switch:**
  - Auto at `sel_out`=3, assert `rst` → 0 next edge.
  - Switching manual(`sel_in`=1)→auto with `period`=1 → 1,1,2,2,3…

Source files
------------

// File: rtl/board_pkg.sv
// Shared constants for the board display/debug path.
// Mode encodings and default divider width.
package board_pkg;

    localparam logic MODE_MANUAL   = 1'b0;
    localparam logic MODE_AUTO     = 1'b1;
    localparam int   DIV_W_DEFAULT = 16;

endpackage

// File: rtl/scan_divider.sv
// Scan-period divider: counts enabled cycles and ticks when count >= period.
// The >= compare lets a lowered period take effect on the very next edge.
module scan_divider
    import board_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q >= period) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N-channel mux with manual select or round-robin auto-scan.
// Drives time-multiplexed display digits via sel_out / ch_onehot.
module chan_scan_mux
    import board_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DIV_W    = DIV_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      hold,
    input  logic [DIV_W-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel_out,
    output logic [CHANNELS-1:0]       ch_onehot,
    output logic                      step,
    output logic                      sel_err
);

    localparam logic [SEL_W:0]   CHAN_N = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST   = SEL_W'(CHANNELS - 1);

    logic                tick;
    logic                manual;
    logic                in_range;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CHANNELS-1:0] oh_q, oh_d;
    logic [WIDTH-1:0]    dout_q, dout_d;
    logic                step_q, step_d;
    logic                err_q, err_d;

    assign manual   = (mode == MODE_MANUAL);
    assign in_range = ({1'b0, sel_in} < CHAN_N);

    scan_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .en     (~manual & ~hold),
        .clr    (manual),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        sel_d  = sel_q;
        step_d = 1'b0;
        err_d  = 1'b0;
        if (manual) begin
            if (in_range) begin
                sel_d = sel_in;
            end else begin
                err_d = 1'b1;
            end
        end else if (tick) begin
            // Explicit wrap so odd channel counts never visit 2^SEL_W-1.
            sel_d  = (sel_q == LAST) ? '0 : sel_q + SEL_W'(1);
            step_d = 1'b1;
        end
    end

    always_comb begin
        oh_d   = '0;
        dout_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            oh_d[k] = (sel_d == SEL_W'(k));
            if (sel_d == SEL_W'(k)) begin
                dout_d = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            oh_q   <= CHANNELS'(1);
            dout_q <= '0;
            step_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            oh_q   <= oh_d;
            dout_q <= dout_d;
            step_q <= step_d;
            err_q  <= err_d;
        end
    end

    assign sel_out   = sel_q;
    assign ch_onehot = oh_q;
    assign dout      = dout_q;
    assign step      = step_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: a 4-channel and a 5-channel instance against a
// cycle-level reference model, plus directed sequences with fixed expectations.
module tb_chan_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        hold;
    logic [15:0] period;
    logic [1:0]  sel_in4;
    logic [2:0]  sel_in5;
    logic [19:0] din4;
    logic [24:0] din5;

    logic [4:0] dout4, dout5;
    logic [1:0] sel4;
    logic [2:0] sel5;
    logic [3:0] oh4;
    logic [4:0] oh5;
    logic       step4, step5, err4, err5;

    int checks = 0;
    int errors = 0;

    int m_sel[2], m_cnt[2], m_dout[2], m_step[2], m_err[2];

    always #5 clk = ~clk;

    chan_scan_mux #(.WIDTH(5), .CHANNELS(4), .DIV_W(16)) u4 (
        .clk(clk), .rst(rst), .mode(mode), .sel_in(sel_in4), .hold(hold),
        .period(period), .din(din4), .dout(dout4), .sel_out(sel4),
        .ch_onehot(oh4), .step(step4), .sel_err(err4)
    );

    chan_scan_mux #(.WIDTH(5), .CHANNELS(5), .DIV_W(16)) u5 (
        .clk(clk), .rst(rst), .mode(mode), .sel_in(sel_in5), .hold(hold),
        .period(period), .din(din5), .dout(dout5), .sel_out(sel5),
        .ch_onehot(oh5), .step(step5), .sel_err(err5)
    );

    function automatic int chan_val(int u, int k);
        if (u == 0) return int'(din4[k*5 +: 5]);
        return int'(din5[k*5 +: 5]);
    endfunction

    // Reference: one clock edge of behaviour for unit u with n channels.
    function automatic void model(int u, int n, int si);
        if (rst) begin
            m_sel[u] = 0; m_cnt[u] = 0; m_dout[u] = 0;
            m_step[u] = 0; m_err[u] = 0;
            return;
        end
        m_step[u] = 0;
        m_err[u]  = 0;
        if (!mode) begin
            m_cnt[u] = 0;
            if (si < n) m_sel[u] = si;
            else m_err[u] = 1;
        end else if (!hold) begin
            if (m_cnt[u] >= int'(period)) begin
                m_cnt[u]  = 0;
                m_sel[u]  = (m_sel[u] + 1) % n;
                m_step[u] = 1;
            end else begin
                m_cnt[u] = m_cnt[u] + 1;
            end
        end
        m_dout[u] = chan_val(u, m_sel[u]);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        model(0, 4, int'(sel_in4));
        model(1, 5, int'(sel_in5));
        @(posedge clk);
        #1;
        chk("u4.sel", int'(sel4), m_sel[0]);
        chk("u4.oh", int'(oh4), 1 << m_sel[0]);
        chk("u4.dout", int'(dout4), m_dout[0]);
        chk("u4.step", int'(step4), m_step[0]);
        chk("u4.err", int'(err4), m_err[0]);
        chk("u5.sel", int'(sel5), m_sel[1]);
        chk("u5.oh", int'(oh5), 1 << m_sel[1]);
        chk("u5.dout", int'(dout5), m_dout[1]);
        chk("u5.step", int'(step5), m_step[1]);
        chk("u5.err", int'(err5), m_err[1]);
    endtask

    int seq4a[13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
    int seq5[6]   = '{0,1,2,3,4,0};
    int seq4b[5]  = '{1,1,2,2,3};
    int held;

    initial begin
        rst = 1'b1; mode = 1'b1; hold = 1'b0; period = 16'd3;
        sel_in4 = 2'd3; sel_in5 = 3'd7;
        din4 = 20'(($urandom)); din5 = 25'($urandom);
        #1;
        // Reset with arbitrary inputs
        cyc(); cyc();
        chk("rst.dout", int'(dout4), 0);
        chk("rst.sel", int'(sel4), 0);
        chk("rst.oh", int'(oh4), 4'b0001);
        chk("rst.step", int'(step4), 0);

        // Manual select and data follow
        rst = 1'b0; mode = 1'b0; sel_in4 = 2'd2; sel_in5 = 3'd1;
        din4 = {5'd3, 5'd2, 5'd1, 5'd0};
        cyc();
        chk("man.dout", int'(dout4), 2);
        chk("man.oh", int'(oh4), 4'b0100);
        din4[10 +: 5] = 5'd17;
        cyc();
        chk("man.dout17", int'(dout4), 17);

        // Auto scan period=2 from reset
        rst = 1'b1; cyc();
        rst = 1'b0; mode = 1'b1; period = 16'd2;
        din4 = 20'($urandom);
        chk("auto2.sel[0]", int'(sel4), seq4a[0]);
        for (int i = 1; i < 13; i++) begin
            cyc();
            chk($sformatf("auto2.sel[%0d]", i), int'(sel4), seq4a[i]);
            chk($sformatf("auto2.step[%0d]", i), int'(step4), (i % 3 == 0) ? 1 : 0);
        end

        // Hold freezes selection and step, then dwell resumes
        cyc();
        hold = 1'b1;
        held = int'(sel4);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold.sel", int'(sel4), held);
            chk("hold.step", int'(step4), 0);
        end
        hold = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        // Period lowered below the running count advances next edge
        rst = 1'b1; cyc();
        rst = 1'b0; period = 16'd10;
        for (int i = 0; i < 5; i++) cyc();
        period = 16'd1;
        cyc();
        chk("perdrop.step", int'(step4), 1);
        chk("perdrop.sel", int'(sel4), 1);

        // Out-of-range manual select on 5 channels
        mode = 1'b0; sel_in5 = 3'd3; cyc();
        sel_in5 = 3'd6; cyc();
        chk("oor.sel", int'(sel5), 3);
        chk("oor.err", int'(err5), 1);
        sel_in5 = 3'd4; cyc();
        chk("oor.err_clr", int'(err5), 0);

        // Auto period=0 wraps 5 channels at 4
        rst = 1'b1; cyc();
        rst = 1'b0; mode = 1'b1; period = 16'd0;
        for (int i = 1; i < 6; i++) begin
            cyc();
            chk($sformatf("p0.sel5[%0d]", i), int'(sel5), seq5[i]);
        end

        // Mid-scan reset
        rst = 1'b1; cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("mid.pre", int'(sel4), 3);
        rst = 1'b1; cyc();
        chk("mid.rst", int'(sel4), 0);
        rst = 1'b0;

        // Manual -> auto resumes from current selection
        mode = 1'b0; sel_in4 = 2'd1; cyc();
        chk("sw.sel[0]", int'(sel4), seq4b[0]);
        mode = 1'b1; period = 16'd1;
        for (int i = 1; i < 5; i++) begin
            cyc();
            chk($sformatf("sw.sel[%0d]", i), int'(sel4), seq4b[i]);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            mode    = ($urandom_range(0, 3) != 0);
            hold    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) period = 16'($urandom_range(0, 5));
            sel_in4 = 2'($urandom);
            sel_in5 = 3'($urandom);
            din4    = 20'($urandom);
            din5    = 25'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
